// File: rtl/pipeline_ifid_hazard_pkg.sv
// Shared definitions for the IF/ID register and hazard/interrupt controller:
// interrupt FSM encoding, IFID field positions and the flush word.
package pipeline_ifid_hazard_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_PEND = 2'd1,
        IRQ_TAKE = 2'd2
    } irq_state_t;

    localparam int IFID_RS_HI = 25;
    localparam int IFID_RS_LO = 21;
    localparam int IFID_RT_HI = 20;
    localparam int IFID_RT_LO = 16;
    localparam int IFID_PC_HI = 63;
    localparam int IFID_PC_LO = 32;

    localparam logic [31:0] NOP_WORD = 32'b0;

endpackage

// File: rtl/pipeline_ifid_hazard_irq_fsm.sv
// Interrupt sequencer: IRQ rising-edge detect plus IDLE/PEND/TAKE FSM.
// IRQ_Take is combinational in the PEND cycle where the pipeline can accept it.
module hazard_irq_fsm
    import pipeline_ifid_hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic IRQ,
    input  logic i_take_ok,
    output logic irq_pend,
    output logic IRQ_Take
);

    irq_state_t r_state;
    logic       r_irq_q;
    logic       w_rise;

    assign w_rise   = IRQ && !r_irq_q;
    assign irq_pend = (r_state == IRQ_PEND);
    assign IRQ_Take = !reset && irq_pend && i_take_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IRQ_IDLE;
            r_irq_q <= 1'b0;
        end else begin
            r_irq_q <= IRQ;
            case (r_state)
                IRQ_IDLE: if (w_rise) r_state <= IRQ_PEND;
                IRQ_PEND: if (i_take_ok) r_state <= IRQ_TAKE;
                // An edge arriving during entry queues a fresh request
                IRQ_TAKE: r_state <= w_rise ? IRQ_PEND : IRQ_IDLE;
                default:  r_state <= IRQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ifid_hazard.sv
// IF/ID register with load-use, branch/jump flush and interrupt-entry control.
// IFID is 1 cycle behind IF; Stall/PCWrite/IRQ_Take are combinational, same cycle.
module pipeline_ifid_hazard
    import pipeline_ifid_hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC_plus4,
    input  logic [31:0]      Instr,
    input  logic             IDEX_MemRd,
    input  logic [4:0]       IDEX_Rt,
    input  logic             EX_BranchTaken,
    input  logic             ID_Jump,
    input  logic             IRQ,
    output logic [63:0]      IFID,
    output logic             IFID_Valid,
    output logic             PCWrite,
    output logic             Stall,
    output logic             IRQ_Take,
    output logic [CNT_W-1:0] BubbleCnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [63:0]      r_ifid;
    logic             r_valid;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_load_use;
    logic       w_take_ok;
    logic       w_irq_pend;

    assign w_rs = r_ifid[IFID_RS_HI:IFID_RS_LO];
    assign w_rt = r_ifid[IFID_RT_HI:IFID_RT_LO];

    assign w_load_use = IDEX_MemRd && (IDEX_Rt != 5'd0) && r_valid &&
                        ((IDEX_Rt == w_rs) || (IDEX_Rt == w_rt));

    // Only a valid sequential instruction may become the EPC source
    assign w_take_ok = !EX_BranchTaken && !w_load_use && !ID_Jump && r_valid;

    hazard_irq_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .IRQ       (IRQ),
        .i_take_ok (w_take_ok),
        .irq_pend  (w_irq_pend),
        .IRQ_Take  (IRQ_Take)
    );

    assign Stall   = reset || EX_BranchTaken || w_load_use;
    assign PCWrite = !reset && (EX_BranchTaken || !w_load_use);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid       <= {NOP_WORD, NOP_WORD};
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (EX_BranchTaken) begin
            r_ifid  <= {NOP_WORD, NOP_WORD};
            r_valid <= 1'b0;
        end else if (w_load_use) begin
            if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end else if (ID_Jump || (w_irq_pend && r_valid)) begin
            r_ifid  <= {NOP_WORD, NOP_WORD};
            r_valid <= 1'b0;
        end else begin
            r_ifid[IFID_PC_HI:IFID_PC_LO] <= PC_plus4;
            r_ifid[31:0]                  <= Instr;
            r_valid                       <= 1'b1;
        end
    end

    assign IFID       = r_ifid;
    assign IFID_Valid = r_valid;
    assign BubbleCnt  = r_bubble_cnt;

endmodule

// File: doc/pipeline_ifid_hazard.md
# pipeline_ifid_hazard

IF/ID stage register of the 5-stage MIPS pipeline, merged with the hazard/flush controller that drives the ID/EX register's `Stall` input. It captures the fetched instruction and PC+4 each cycle and detects load-use hazards against the instruction in ID/EX. It resolves flushes from taken branches (EX) and jumps (ID), and sequences one external interrupt into the pipeline. It also keeps a saturating count of inserted load-use bubbles.

## Interface
Parameters:
- `CNT_W`, 16, width of the load-use bubble counter

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high
- `PC_plus4`  in  32  PC+4 from IF
- `Instr`  in  32  instruction from IF
- `IDEX_MemRd`  in  1  instruction in ID/EX is a load
- `IDEX_Rt`  in  5  load destination register in ID/EX
- `EX_BranchTaken`  in  1  branch resolved taken in EX this cycle
- `ID_Jump`  in  1  J/JAL/JR/JALR decoded in ID this cycle
- `IRQ`  in  1  external interrupt request, level, synchronous to `clk`
- `IFID`  out  64  `{PC_plus4, Instr}`, registered
- `IFID_Valid`  out  1  `IFID` holds a real instruction
- `PCWrite`  out  1  PC register enable
- `Stall`  out  1  bubble/flush request to the ID/EX register (zeroes it)
- `IRQ_Take`  out  1  one-cycle interrupt-entry pulse (PC mux selects vector; `IFID[63:32]` is EPC source)
- `BubbleCnt`  out  `CNT_W`  saturating count of load-use bubbles

## Operation
- Field decode from the register: `IFID_Rs = IFID[25:21]`, `IFID_Rt = IFID[20:16]`.
- Load-use is `IDEX_MemRd && IDEX_Rt != 0 && IFID_Valid && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt)`.
- Each cycle selects exactly one action, in this priority:
  1. `EX_BranchTaken`: IFID←0, Valid←0, `Stall`=1, `PCWrite`=1.
  2. Load-use: IFID and Valid hold, `Stall`=1, `PCWrite`=0, `BubbleCnt`+1 (saturating at all-ones).
  3. `ID_Jump`: IFID←0, Valid←0, `Stall`=0, `PCWrite`=1.
  4. Interrupt take (see the FSM): IFID←0, Valid←0, `Stall`=0, `PCWrite`=1, `IRQ_Take`=1.
  5. Normal: IFID←`{PC_plus4, Instr}`, Valid←1, `Stall`=0, `PCWrite`=1.
- Interrupt FSM states are IDLE, PEND and TAKE. `irq_q` is a registered copy of `IRQ`; a rising edge is `IRQ && !irq_q`.
  - IDLE→PEND on a rising edge.
  - PEND→TAKE when priorities 1–3 are all inactive and `IFID_Valid`=1. `IRQ_Take` is asserted combinationally in that cycle.
  - TAKE→IDLE unconditionally after one cycle. A rising edge seen in TAKE goes to PEND instead.
  - PEND holds through branch, load-use and jump cycles.
- `IRQ_Take` is never asserted while a branch/jump flush is in progress, so EPC is always a sequential-path PC.

## Timing
- All state updates on the `posedge clk`: IFID, Valid, FSM, `irq_q`, `BubbleCnt`.
- `Stall`, `PCWrite` and `IRQ_Take` are combinational from current state and inputs, valid in the same cycle.
- Latency from IF to the `IFID` output is 1 cycle.
- A load-use stall lasts exactly 1 cycle: next cycle ID/EX holds a bubble (`IDEX_MemRd`=0), so the stall drops.
- Reset (sync, with priority over everything, also mid-stall or mid-IRQ):
  - IFID=0, Valid=0, FSM=IDLE, `irq_q`=0, `BubbleCnt`=0.
  - While `reset`=1: `Stall`=1, `PCWrite`=0, `IRQ_Take`=0.
- Simultaneous branch and load-use: the branch wins; the counter does not increment.
- `BubbleCnt` at all-ones stays at all-ones.

## Structure
- Shared package holds the IRQ state encoding (IDLE=2'd0, PEND=2'd1, TAKE=2'd2), the `IFID` field slice constants (Rs, Rt, PC) and `NOP_WORD`=32'b0.
- One sub-module, `hazard_irq_fsm`: edge detect plus the 3-state FSM, outputs `irq_pend` and `IRQ_Take`.
- Priority select and the IFID register live in the top module.

## Test plan
- Normal flow: `PC_plus4`=0x04, `Instr`=0x8C430000, no hazards → after 1 edge `IFID`=0x00000004_8C430000, Valid=1, `Stall`=0, `PCWrite`=1.
- Load-use: IFID holds `add $4,$3,$5`, `IDEX_MemRd`=1, `IDEX_Rt`=3 → `Stall`=1, `PCWrite`=0, IFID unchanged for 1 cycle, `BubbleCnt`=1. Repeat with `IDEX_Rt`=0 → no stall.
- Branch and load-use in the same cycle → IFID=0, Valid=0, `Stall`=1, `PCWrite`=1, `BubbleCnt` unchanged.
- `ID_Jump`=1 → IFID=0, Valid=0, `Stall`=0; the next fetched instruction is captured on the following edge.
- IRQ rises during a load-use cycle:
  - First valid non-hazard cycle after it → `IRQ_Take`=1 for exactly 1 cycle, IFID flushed, FSM back in IDLE.
  - Holding `IRQ` high gives no second take.
- Reset asserted while in PEND with Valid=1 → next edge FSM=IDLE, IFID=0, `BubbleCnt`=0. While `reset` is high, `Stall`=1 and `PCWrite`=0.
- Saturation: preload 2^`CNT_W`−1 bubbles, then one more load-use → count stays at all-ones.
